nes_input_port: RTL and testbench

NES_INPUT_PORT -- requirements
Module: nes_input_port

---
 rtl/nes_input_pkg.sv | 22 ++
 rtl/nes_input_chan.sv | 49 ++++
 rtl/nes_input_port.sv | 75 +++++++
 tb/tb_nes_input_port.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_input_pkg.sv
// nes_input_pkg: shared types and constants for the NES $4016/$4017 controller ports.
// NES_FOUR_SCORE_EN selects the 24-bit multitap frame instead of the 8-bit pad frame.
package nes_input_pkg;
    typedef enum logic [1:0] {CH_RELOAD, CH_SHIFT, CH_DONE} chan_state_e;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam logic [7:0] SIG_P1 = 8'h10;
    localparam logic [7:0] SIG_P2 = 8'h20;
    localparam int LIMIT_STD = 8;
    localparam int LIMIT_4S  = 24;
`ifdef NES_FOUR_SCORE_EN
    localparam int FRAME_W = LIMIT_4S;
`else
    localparam int FRAME_W = LIMIT_STD;
`endif
endpackage

// File: rtl/nes_input_chan.sv
// nes_input_chan: one controller port shift channel (reload / shift / done), D0 output.
module nes_input_chan
    import nes_input_pkg::*;
#(
    parameter int W = LIMIT_STD
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_strobe,
    input  logic         i_rd,
    input  logic         i_clr,
    input  logic [W-1:0] i_vec,
    output logic         o_d0
);
    localparam logic [4:0] LIM = 5'(W);
    chan_state_e  r_state, w_state, w_next;
    logic [W-1:0] r_shift, w_shift, w_sh;
    logic [4:0]   r_cnt, w_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CH_SHIFT;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
        end
    end
    // i_strobe is already the post-write strobe, so w_state is the state a same-cycle read sees
    always_comb begin
        w_state = i_strobe ? CH_RELOAD : (r_state == CH_RELOAD ? CH_SHIFT : r_state);
        w_sh    = r_shift >> r_cnt;
        o_d0    = w_state == CH_RELOAD ? i_vec[BTN_A] : (w_state == CH_SHIFT ? w_sh[0] : 1'b1);
        w_next  = w_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        if (i_strobe) begin
            w_shift = i_vec;
            w_cnt   = '0;
        end else if (i_clr) begin
            w_next = CH_SHIFT;
            w_cnt  = '0;
        end else if (i_rd && w_state == CH_SHIFT) begin
            w_cnt  = r_cnt + 5'd1;
            w_next = (r_cnt + 5'd1 == LIM) ? CH_DONE : CH_SHIFT;
        end
    end
endmodule

// File: rtl/nes_input_port.sv
// nes_input_port: NES $4016/$4017 input block with two pad channels and a port-2 zapper.
// NES_FOUR_SCORE_EN adds joy3/joy4 and the Four Score signature frame.
module nes_input_port
    import nes_input_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       strobe_wr,
    input  logic       wr_data,
    input  logic [1:0] rd_req,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
`ifdef NES_FOUR_SCORE_EN
    input  logic [7:0] joy3,
    input  logic [7:0] joy4,
`endif
    input  logic       port2_zapper,
    input  logic       zapper_light,
    input  logic       zapper_trigger,
    output logic [4:0] rd_data,
    output logic       rd_valid
);
    logic               r_strobe, r_zap_q, r_rd_valid;
    logic [4:0]         r_rd_data;
    logic               w_strobe, w_rd1, w_rd2, w_clr2, w_d0_1, w_d0_2;
    logic [FRAME_W-1:0] w_vec1, w_vec2;
`ifdef NES_FOUR_SCORE_EN
    assign w_vec1 = {SIG_P1, joy3, joy1};
    assign w_vec2 = {SIG_P2, joy4, joy2};
`else
    assign w_vec1 = joy1;
    assign w_vec2 = joy2;
`endif
    // $4016 has priority; a zapper read never advances the port-2 channel
    assign w_strobe = strobe_wr ? wr_data : r_strobe;
    assign w_rd1    = rd_req[0];
    assign w_rd2    = rd_req[1] & ~rd_req[0] & ~port2_zapper;
    assign w_clr2   = port2_zapper ^ r_zap_q;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    nes_input_chan #(.W(FRAME_W)) u_chan1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_strobe (w_strobe),
        .i_rd     (w_rd1),
        .i_clr    (1'b0),
        .i_vec    (w_vec1),
        .o_d0     (w_d0_1)
    );
    nes_input_chan #(.W(FRAME_W)) u_chan2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_strobe (w_strobe),
        .i_rd     (w_rd2),
        .i_clr    (w_clr2),
        .i_vec    (w_vec2),
        .o_d0     (w_d0_2)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe   <= 1'b0;
            r_zap_q    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_strobe   <= w_strobe;
            r_zap_q    <= port2_zapper;
            r_rd_valid <= |rd_req;
            if (rd_req[0])
                r_rd_data <= {4'b0, w_d0_1};
            else if (rd_req[1])
                r_rd_data <= port2_zapper ? {zapper_trigger, zapper_light, 3'b0} : {4'b0, w_d0_2};
        end
    end
endmodule

// File: tb/tb_nes_input_port.sv
// tb_nes_input_port: directed scoreboard bench for nes_input_port (default and NES_FOUR_SCORE_EN builds).
module tb_nes_input_port;
`ifdef NES_FOUR_SCORE_EN
    localparam int LIM = 24;
`else
    localparam int LIM = 8;
`endif
    logic       clk = 0;
    logic       reset_n = 0;
    logic       strobe_wr = 0, wr_data = 0;
    logic [1:0] rd_req = 0;
    logic [7:0] joy1 = 0, joy2 = 0, joy3 = 0, joy4 = 0;
    logic       port2_zapper = 0, zapper_light = 1, zapper_trigger = 0;
    logic [4:0] rd_data;
    logic       rd_valid;
    int         tests = 0, fails = 0, n_push = 0, n_valid = 0;
    logic [4:0] exp_q[$];
    string      tag_q[$];

    nes_input_port dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .strobe_wr      (strobe_wr),
        .wr_data        (wr_data),
        .rd_req         (rd_req),
        .joy1           (joy1),
        .joy2           (joy2),
`ifdef NES_FOUR_SCORE_EN
        .joy3           (joy3),
        .joy4           (joy4),
`endif
        .port2_zapper   (port2_zapper),
        .zapper_light   (zapper_light),
        .zapper_trigger (zapper_trigger),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] frame(input logic [7:0] sig, input logic [7:0] jx, input logic [7:0] j);
`ifdef NES_FOUR_SCORE_EN
        return {sig, jx, j};
`else
        return {16'h0, j};
`endif
    endfunction

    function automatic logic exp_bit(input logic [23:0] f, input int k);
        return (k <= LIM) ? f[k-1] : 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rd_valid) begin
            logic [4:0] e;
            string      t;
            n_valid++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL unexpected_valid: rd_data=%b expected no read", rd_data);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                assert (rd_data === e) else begin
                    fails++;
                    $error("FAIL %s: rd_data=%b expected %b", t, rd_data, e);
                end
            end
        end
    end

    task automatic rd(input int p, input logic [4:0] e, input string t);
        @(negedge clk);
        rd_req = (p == 0) ? 2'b01 : 2'b10;
        exp_q.push_back(e);
        tag_q.push_back(t);
        n_push++;
        @(negedge clk);
        rd_req = 2'b00;
    endtask

    task automatic wr(input logic v);
        @(negedge clk);
        strobe_wr = 1;
        wr_data = v;
        @(negedge clk);
        strobe_wr = 0;
    endtask

    task automatic seq(input int p, input logic [23:0] f, input int n, input string t);
        for (int k = 1; k <= n; k++)
            rd(p, {4'b0, exp_bit(f, k)}, $sformatf("%s_r%0d", t, k));
    endtask

    task automatic chk_reset(input string t);
        tests++;
        assert (rd_data === 5'd0 && rd_valid === 1'b0) else begin
            fails++;
            $error("FAIL %s: rd_data=%b rd_valid=%b expected 00000/0", t, rd_data, rd_valid);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset_state");
        reset_n = 1;
        // basic 8-bit sequence, saturating at 1
        joy1 = 8'h81;
        wr(1);
        wr(0);
        seq(0, frame(8'h10, joy3, 8'h81), 10, "seq81");
        // strobe held high tracks live A
        wr(1);
        joy1 = 8'h01;
        rd(0, 5'b00001, "live_a1");
        joy1 = 8'h00;
        rd(0, 5'b00000, "live_a0");
        joy1 = 8'h01;
        rd(0, 5'b00001, "live_a1b");
        wr(0);
        joy1 = 8'hFE;
        seq(0, frame(8'h10, joy3, 8'h01), 9, "snapshot");
        // zapper on port 2
        port2_zapper = 1;
        zapper_light = 0;
        zapper_trigger = 1;
        rd(1, 5'b10000, "zap_trig");
        zapper_light = 1;
        zapper_trigger = 0;
        rd(1, 5'b01000, "zap_light");
        port2_zapper = 0;
        // simultaneous $4016/$4017 read
        joy1 = 8'h01;
        joy2 = 8'h00;
        wr(1);
        wr(0);
        @(negedge clk);
        rd_req = 2'b11;
        exp_q.push_back(5'b00001);
        tag_q.push_back("dual_rd");
        n_push++;
        @(negedge clk);
        rd_req = 2'b00;
        seq(1, frame(8'h20, joy4, 8'h00), LIM + 1, "p2_after_dual");
        // zapper toggle restarts port 2 at bit0
        joy2 = 8'h09;
        wr(1);
        wr(0);
        rd(1, 5'b00001, "p2_b0");
        rd(1, 5'b00000, "p2_b1");
        @(negedge clk);
        port2_zapper = 1;
        @(negedge clk);
        port2_zapper = 0;
        @(negedge clk);
        rd(1, 5'b00001, "p2_clr_b0");
        rd(1, 5'b00000, "p2_clr_b1");
        // reset mid-sequence
        joy1 = 8'h81;
        wr(1);
        wr(0);
        seq(0, frame(8'h10, joy3, 8'h81), 3, "pre_reset");
        @(negedge clk);
        reset_n = 0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        reset_n = 1;
        rd(0, 5'b00000, "post_reset");
        wr(1);
        wr(0);
        seq(0, frame(8'h10, joy3, 8'h81), LIM + 1, "restart");
        // strobe write and read in same cycle: read sees RELOAD (live A=0), not DONE
        joy1 = 8'h00;
        @(negedge clk);
        strobe_wr = 1;
        wr_data = 1;
        rd_req = 2'b01;
        exp_q.push_back(5'b00000);
        tag_q.push_back("wr_rd_same");
        n_push++;
        @(negedge clk);
        strobe_wr = 0;
        rd_req = 2'b00;
        wr(0);
`ifdef NES_FOUR_SCORE_EN
        joy1 = 8'h00;
        joy3 = 8'h00;
        wr(1);
        wr(0);
        seq(0, frame(8'h10, 8'h00, 8'h00), 25, "fs_p1");
`endif
        repeat (4) @(negedge clk);
        tests++;
        assert (exp_q.size() == 0 && n_valid == n_push) else begin
            fails++;
            $error("FAIL drain: pending=%0d valids=%0d expected 0/%0d", exp_q.size(), n_valid, n_push);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
